cache_axi_arbiter: RTL and testbench

- Memory-side controller shared by icache and dcache.
- Sequences icache line fills, dcache line fills, dirty line write-backs and uncached single-word accesses onto one AXI4 master port: 32-bit data, INCR bursts, one outstanding read plus one outstanding write.
- Generates the level-type dev_rrdy/dev_wrdy/icache_rrdy availability signals and the single-cycle completion pulses the caches expect.

---
 rtl/cache_axi_arbiter_pkg.sv | 19 +
 rtl/cache_axi_arbiter_if.sv | 60 ++++++
 rtl/cache_axi_arbiter_axi_wr_channel.sv | 109 ++++++++++
 rtl/cache_axi_arbiter.sv | 176 +++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_axi_arbiter_pkg.sv
// Shared encodings and AXI constants for the cache-side AXI arbiter.
package cache_axi_arbiter_pkg;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam int         LINE_BEATS = 4;
   localparam logic [7:0] LEN_LINE   = 8'(LINE_BEATS - 1);
   localparam logic [7:0] LEN_WORD   = 8'd0;
   localparam logic [1:0] CNT_LAST   = 2'(LINE_BEATS - 1);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;
   typedef enum logic [1:0] {SRC_ICACHE, SRC_DCACHE, SRC_UNCACHE} rd_src_e;

   function automatic logic [31:0] line_align(input logic [31:0] addr);
      return {addr[31:4], 4'b0000};
   endfunction

endpackage

// File: rtl/cache_axi_arbiter_if.sv
// AXI4 master bus between the cache arbiter and memory.
interface cache_axi_arbiter_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/cache_axi_arbiter_axi_wr_channel.sv
// Write path: dirty line write-backs and uncached single-word stores.
// state  | meaning
// W_IDLE | free, accepts a line write-back or an uncached store
// W_AW   | address presented, waiting for awready
// W_DATA | streaming beats from the buffer
// W_RESP | waiting for the B response
module axi_wr_channel
   import cache_axi_arbiter_pkg::*;
#(
   parameter logic [3:0] AWID = 4'd1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   cpu_wen,
   input  logic [31:0]  cpu_waddr,
   input  logic [127:0] cpu_wdata,
   input  logic [3:0]   uncache_wen,
   input  logic [31:0]  uncache_waddr,
   input  logic [31:0]  uncache_wdata,
   output logic         wr_idle,
   output logic [3:0]   awid,
   output logic [31:0]  awaddr,
   output logic [7:0]   awlen,
   output logic [2:0]   awsize,
   output logic [1:0]   awburst,
   output logic         awvalid,
   input  logic         awready,
   output logic [31:0]  wdata,
   output logic [3:0]   wstrb,
   output logic         wlast,
   output logic         wvalid,
   input  logic         wready,
   input  logic         bvalid,
   output logic         bready
);

   wr_state_e    state, state_nxt;
   logic [31:0]  aw_addr;
   logic [7:0]   aw_len;
   logic [3:0]   strb;
   logic [127:0] wbuf;
   logic [1:0]   cnt;
   logic         single;
   logic         last_beat;
   logic         unused_addr;

   assign unused_addr = ^cpu_waddr[3:0];
   assign last_beat   = single | (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= W_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         W_IDLE: if ((|cpu_wen) || (|uncache_wen)) state_nxt = W_AW;
         W_AW:   if (awready) state_nxt = W_DATA;
         W_DATA: if (wready && last_beat) state_nxt = W_RESP;
         W_RESP: if (bvalid) state_nxt = W_IDLE;
         default: state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_addr <= '0;
         aw_len  <= '0;
         strb    <= '0;
         wbuf    <= '0;
         cnt     <= '0;
         single  <= 1'b0;
      end else begin
         if (state == W_IDLE) begin
            cnt <= '0;
            // write-back wins over an uncached store in the same cycle
            if (|cpu_wen) begin
               aw_addr <= line_align(cpu_waddr);
               aw_len  <= LEN_LINE;
               strb    <= 4'hF;
               wbuf    <= cpu_wdata;
               single  <= 1'b0;
            end else if (|uncache_wen) begin
               aw_addr <= uncache_waddr;
               aw_len  <= LEN_WORD;
               strb    <= uncache_wen;
               wbuf    <= {96'b0, uncache_wdata};
               single  <= 1'b1;
            end
         end
         if (state == W_DATA && wready && !last_beat) cnt <= cnt + 2'd1;
      end
   end

   assign wr_idle = (state == W_IDLE);
   assign awid    = AWID;
   assign awaddr  = aw_addr;
   assign awlen   = aw_len;
   assign awsize  = SIZE_4B;
   assign awburst = BURST_INCR;
   assign awvalid = (state == W_AW);
   assign wdata   = wbuf[{cnt, 5'b00000} +: 32];
   assign wstrb   = strb;
   assign wlast   = (state == W_DATA) & last_beat;
   assign wvalid  = (state == W_DATA);
   assign bready  = (state == W_RESP);

endmodule

// File: rtl/cache_axi_arbiter.sv
// Memory-side arbiter: icache/dcache fills and uncached accesses on one AXI4 master.
// state  | meaning
// R_IDLE | read path free, arbitrating icache vs dcache/uncached
// R_AR   | address presented, waiting for arready
// R_DATA | collecting beats into the line buffer
// R_DONE | one-cycle completion pulse to the latched source
module cache_axi_arbiter
   import cache_axi_arbiter_pkg::*;
#(
   parameter bit         DCACHE_FIRST = 1'b1,
   parameter logic [3:0] ARID_I       = 4'd0,
   parameter logic [3:0] ARID_D       = 4'd1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          icache_ren,
   input  logic [31:0]   icache_raddr,
   output logic          icache_rrdy,
   output logic          icache_rvalid,
   output logic [127:0]  icache_rdata,
   input  logic [3:0]    cpu_ren,
   input  logic [31:0]   cpu_raddr,
   output logic          dev_rrdy,
   output logic          dev_rvalid,
   output logic [127:0]  dev_rdata,
   input  logic          uncache_ren,
   input  logic [31:0]   uncache_raddr,
   output logic          uncache_rvalid,
   output logic [31:0]   uncache_rdata,
   input  logic [3:0]    cpu_wen,
   input  logic [31:0]   cpu_waddr,
   input  logic [127:0]  cpu_wdata,
   input  logic [3:0]    uncache_wen,
   input  logic [31:0]   uncache_waddr,
   input  logic [31:0]   uncache_wdata,
   output logic          dev_wrdy,
   cache_axi_arbiter_if.master axi
);

   rd_state_e    r_state, r_state_nxt;
   rd_src_e      r_src;
   logic [31:0]  ar_addr;
   logic [7:0]   ar_len;
   logic [3:0]   ar_id;
   logic         r_single;
   logic [1:0]   r_cnt;
   logic [127:0] r_buf, r_line_nxt;
   logic         r_idle, r_beat, r_last_beat;
   logic         w_idle, dreq, ireq;
   logic         unused_inputs;

   assign unused_inputs = ^{axi.rid, axi.rresp, axi.bid, axi.bresp,
                            cpu_raddr[3:0], icache_raddr[3:0]};

   // dev_rrdy also waits on the write path so an uncached store lands before a later load
   assign r_idle      = (r_state == R_IDLE);
   assign dev_rrdy    = r_idle & w_idle & (DCACHE_FIRST | ~icache_ren);
   assign dreq        = dev_rrdy & ((|cpu_ren) | uncache_ren);
   assign icache_rrdy = r_idle & ~(DCACHE_FIRST & dreq);
   assign ireq        = icache_rrdy & icache_ren;

   assign r_beat      = (r_state == R_DATA) & axi.rvalid;
   assign r_last_beat = axi.rlast | (~r_single & (r_cnt == CNT_LAST));

   always_comb begin
      r_line_nxt = r_buf;
      r_line_nxt[{r_cnt, 5'b00000} +: 32] = axi.rdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= R_IDLE;
      else      r_state <= r_state_nxt;
   end

   always_comb begin
      r_state_nxt = r_state;
      case (r_state)
         R_IDLE: if (dreq || ireq) r_state_nxt = R_AR;
         R_AR:   if (axi.arready) r_state_nxt = R_DATA;
         R_DATA: if (r_beat && r_last_beat) r_state_nxt = R_DONE;
         R_DONE: r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_src         <= SRC_ICACHE;
         ar_addr       <= '0;
         ar_len        <= '0;
         ar_id         <= '0;
         r_single      <= 1'b0;
         r_cnt         <= '0;
         r_buf         <= '0;
         icache_rdata  <= '0;
         dev_rdata     <= '0;
         uncache_rdata <= '0;
      end else begin
         if (r_idle) begin
            r_cnt <= '0;
            if (dreq) begin
               ar_id <= ARID_D;
               if (|cpu_ren) begin
                  r_src    <= SRC_DCACHE;
                  r_single <= 1'b0;
                  ar_addr  <= line_align(cpu_raddr);
                  ar_len   <= LEN_LINE;
               end else begin
                  r_src    <= SRC_UNCACHE;
                  r_single <= 1'b1;
                  ar_addr  <= uncache_raddr;
                  ar_len   <= LEN_WORD;
               end
            end else if (ireq) begin
               ar_id    <= ARID_I;
               r_src    <= SRC_ICACHE;
               r_single <= 1'b0;
               ar_addr  <= line_align(icache_raddr);
               ar_len   <= LEN_LINE;
            end
         end
         // result registers update on the final beat so data is valid during R_DONE and after
         if (r_beat) begin
            r_buf <= r_line_nxt;
            r_cnt <= r_cnt + 2'd1;
            if (r_last_beat) begin
               case (r_src)
                  SRC_ICACHE: icache_rdata  <= r_line_nxt;
                  SRC_DCACHE: dev_rdata     <= r_line_nxt;
                  default:    uncache_rdata <= axi.rdata;
               endcase
            end
         end
      end
   end

   assign axi.arid    = ar_id;
   assign axi.araddr  = ar_addr;
   assign axi.arlen   = ar_len;
   assign axi.arsize  = SIZE_4B;
   assign axi.arburst = BURST_INCR;
   assign axi.arvalid = (r_state == R_AR);
   assign axi.rready  = (r_state == R_DATA);

   assign icache_rvalid  = (r_state == R_DONE) & (r_src == SRC_ICACHE);
   assign dev_rvalid     = (r_state == R_DONE) & (r_src == SRC_DCACHE);
   assign uncache_rvalid = (r_state == R_DONE) & (r_src == SRC_UNCACHE);
   assign dev_wrdy       = w_idle;

   axi_wr_channel #(.AWID(ARID_D)) u_wr (
      .clk           (clk),
      .rst           (rst),
      .cpu_wen       (cpu_wen),
      .cpu_waddr     (cpu_waddr),
      .cpu_wdata     (cpu_wdata),
      .uncache_wen   (uncache_wen),
      .uncache_waddr (uncache_waddr),
      .uncache_wdata (uncache_wdata),
      .wr_idle       (w_idle),
      .awid          (axi.awid),
      .awaddr        (axi.awaddr),
      .awlen         (axi.awlen),
      .awsize        (axi.awsize),
      .awburst       (axi.awburst),
      .awvalid       (axi.awvalid),
      .awready       (axi.awready),
      .wdata         (axi.wdata),
      .wstrb         (axi.wstrb),
      .wlast         (axi.wlast),
      .wvalid        (axi.wvalid),
      .wready        (axi.wready),
      .bvalid        (axi.bvalid),
      .bready        (axi.bready)
   );

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Scenario bench for cache_axi_arbiter with an inline AXI slave and expectation queues.
module tb_cache_axi_arbiter;

   typedef struct packed {logic [3:0] id; logic [31:0] addr; logic [7:0] len;} addr_exp_t;
   typedef struct packed {logic [2:0] pulses; logic [127:0] data;} done_exp_t;
   typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} beat_exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          icache_ren = 1'b0;
   logic [31:0]   icache_raddr = '0;
   logic          icache_rrdy, icache_rvalid;
   logic [127:0]  icache_rdata;
   logic [3:0]    cpu_ren = '0;
   logic [31:0]   cpu_raddr = '0;
   logic          dev_rrdy, dev_rvalid;
   logic [127:0]  dev_rdata;
   logic          uncache_ren = 1'b0;
   logic [31:0]   uncache_raddr = '0;
   logic          uncache_rvalid;
   logic [31:0]   uncache_rdata;
   logic [3:0]    cpu_wen = '0;
   logic [31:0]   cpu_waddr = '0;
   logic [127:0]  cpu_wdata = '0;
   logic [3:0]    uncache_wen = '0;
   logic [31:0]   uncache_waddr = '0;
   logic [31:0]   uncache_wdata = '0;
   logic          dev_wrdy;

   int checks = 0;
   int errors = 0;

   addr_exp_t ar_q[$];
   addr_exp_t aw_q[$];
   done_exp_t done_q[$];
   beat_exp_t w_q[$];

   cache_axi_arbiter_if axi();

   cache_axi_arbiter dut (
      .clk(clk), .rst(rst),
      .icache_ren(icache_ren), .icache_raddr(icache_raddr), .icache_rrdy(icache_rrdy),
      .icache_rvalid(icache_rvalid), .icache_rdata(icache_rdata),
      .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .dev_rrdy(dev_rrdy),
      .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
      .uncache_ren(uncache_ren), .uncache_raddr(uncache_raddr),
      .uncache_rvalid(uncache_rvalid), .uncache_rdata(uncache_rdata),
      .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
      .uncache_wen(uncache_wen), .uncache_waddr(uncache_waddr), .uncache_wdata(uncache_wdata),
      .dev_wrdy(dev_wrdy),
      .axi(axi)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [127:0] pick_data(input logic [2:0] pulses);
      case (pulses)
         3'b100:  return icache_rdata;
         3'b010:  return dev_rdata;
         default: return {96'b0, uncache_rdata};
      endcase
   endfunction

   task automatic serve_read(input logic [127:0] line, input int nbeats, input logic [1:0] resp);
      addr_exp_t ea;
      done_exp_t ed;
      logic [2:0] pv;
      logic [127:0] got;
      int t = 0;
      while (axi.arvalid !== 1'b1 && t < 50) begin tick(); t++; end
      checks++;
      if (axi.arvalid !== 1'b1 || ar_q.size() == 0) begin
         errors++;
         $display("FAIL ar_wait arvalid=%b queued=%0d required arvalid 1", axi.arvalid, ar_q.size());
         return;
      end
      ea = ar_q.pop_front();
      checks++;
      if ({axi.arid, axi.araddr, axi.arlen} !== {ea.id, ea.addr, ea.len}) begin
         errors++;
         $display("FAIL ar_fields got id=%h addr=%h len=%h required id=%h addr=%h len=%h",
                  axi.arid, axi.araddr, axi.arlen, ea.id, ea.addr, ea.len);
      end
      checks++;
      if ({axi.arsize, axi.arburst} !== {3'b010, 2'b01}) begin
         errors++;
         $display("FAIL ar_size_burst got %b/%b required 010/01", axi.arsize, axi.arburst);
      end
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      checks++;
      if (axi.rready !== 1'b1) begin
         errors++;
         $display("FAIL rready got %b required 1", axi.rready);
      end
      for (int i = 0; i < nbeats; i++) begin
         axi.rvalid = 1'b1;
         axi.rdata  = line[32*i +: 32];
         axi.rlast  = (i == nbeats - 1);
         axi.rresp  = resp;
         tick();
      end
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rresp  = 2'b00;
      t = 0;
      while ({icache_rvalid, dev_rvalid, uncache_rvalid} == 3'b000 && t < 20) begin tick(); t++; end
      ed = done_q.pop_front();
      pv = {icache_rvalid, dev_rvalid, uncache_rvalid};
      checks++;
      if (pv !== ed.pulses) begin
         errors++;
         $display("FAIL done_pulse got %b required %b", pv, ed.pulses);
      end
      got = pick_data(ed.pulses);
      checks++;
      if (got !== ed.data) begin
         errors++;
         $display("FAIL done_data got %h required %h", got, ed.data);
      end
      checks++;
      if (dev_rrdy !== 1'b0) begin
         errors++;
         $display("FAIL rrdy_in_done got %b required 0", dev_rrdy);
      end
      tick();
      pv = {icache_rvalid, dev_rvalid, uncache_rvalid};
      checks++;
      if (pv !== 3'b000) begin
         errors++;
         $display("FAIL pulse_width got %b required 000", pv);
      end
      got = pick_data(ed.pulses);
      checks++;
      if (got !== ed.data) begin
         errors++;
         $display("FAIL data_hold got %h required %h", got, ed.data);
      end
   endtask

   task automatic serve_write(input int stall_beat);
      addr_exp_t ea;
      beat_exp_t eb;
      int t = 0;
      while (axi.awvalid !== 1'b1 && t < 50) begin tick(); t++; end
      checks++;
      if (axi.awvalid !== 1'b1 || aw_q.size() == 0) begin
         errors++;
         $display("FAIL aw_wait awvalid=%b queued=%0d required awvalid 1", axi.awvalid, aw_q.size());
         return;
      end
      ea = aw_q.pop_front();
      checks++;
      if ({axi.awid, axi.awaddr, axi.awlen} !== {ea.id, ea.addr, ea.len}) begin
         errors++;
         $display("FAIL aw_fields got id=%h addr=%h len=%h required id=%h addr=%h len=%h",
                  axi.awid, axi.awaddr, axi.awlen, ea.id, ea.addr, ea.len);
      end
      axi.awready = 1'b1;
      tick();
      axi.awready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (w_q.size() == 0) break;
         eb = w_q.pop_front();
         t = 0;
         while (axi.wvalid !== 1'b1 && t < 20) begin tick(); t++; end
         checks++;
         if ({axi.wvalid, axi.wdata, axi.wstrb, axi.wlast} !== {1'b1, eb.data, eb.strb, eb.last}) begin
            errors++;
            $display("FAIL w_beat%0d got v=%b d=%h s=%h l=%b required v=1 d=%h s=%h l=%b", i,
                     axi.wvalid, axi.wdata, axi.wstrb, axi.wlast, eb.data, eb.strb, eb.last);
         end
         if (i == stall_beat) begin
            repeat (2) begin
               tick();
               checks++;
               if ({axi.wvalid, axi.wdata} !== {1'b1, eb.data}) begin
                  errors++;
                  $display("FAIL w_hold got v=%b d=%h required v=1 d=%h", axi.wvalid, axi.wdata, eb.data);
               end
            end
         end
         axi.wready = 1'b1;
         tick();
         axi.wready = 1'b0;
         if (eb.last) break;
      end
      t = 0;
      while (axi.bready !== 1'b1 && t < 20) begin tick(); t++; end
      checks++;
      if (axi.bready !== 1'b1) begin
         errors++;
         $display("FAIL bready got %b required 1", axi.bready);
      end
      axi.bvalid = 1'b1;
      #1;
      checks++;
      if ({dev_wrdy, axi.arvalid} !== 2'b00) begin
         errors++;
         $display("FAIL wrdy_arvalid_in_resp got %b%b required 00", dev_wrdy, axi.arvalid);
      end
      tick();
      axi.bvalid = 1'b0;
      checks++;
      if ({dev_wrdy, axi.arvalid} !== 2'b10) begin
         errors++;
         $display("FAIL wrdy_after_b got wrdy=%b arvalid=%b required wrdy=1 arvalid=0", dev_wrdy, axi.arvalid);
      end
   endtask

   task automatic run_fill(input logic [31:0] addr, input logic [127:0] line);
      ar_q.push_back('{id: 4'd1, addr: {addr[31:4], 4'b0000}, len: 8'd3});
      done_q.push_back('{pulses: 3'b010, data: line});
      cpu_ren   = 4'hF;
      cpu_raddr = addr;
      tick();
      cpu_ren = 4'h0;
      checks++;
      if (dev_rrdy !== 1'b0) begin
         errors++;
         $display("FAIL rrdy_after_accept got %b required 0", dev_rrdy);
      end
      serve_read(line, 4, 2'b00);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_axi got %b required 00000",
                  {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready});
      end
      checks++;
      if ({icache_rvalid, dev_rvalid, uncache_rvalid, dev_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_pulses_data got %b%b%b %h required 0", icache_rvalid, dev_rvalid,
                  uncache_rvalid, dev_rdata);
      end
      checks++;
      if ({dev_rrdy, dev_wrdy, icache_rrdy} !== 3'b111) begin
         errors++;
         $display("FAIL reset_rdy got %b required 111", {dev_rrdy, dev_wrdy, icache_rrdy});
      end
   endtask

   task automatic test_dcache_fill();
      run_fill(32'h1C00_0128, {32'h44, 32'h33, 32'h22, 32'h11});
      checks++;
      if (dev_rrdy !== 1'b1) begin
         errors++;
         $display("FAIL rrdy_after_done got %b required 1", dev_rrdy);
      end
   endtask

   task automatic test_conflict();
      int t = 0;
      logic [127:0] dline = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
      logic [127:0] iline = {32'h1313_0003, 32'h1212_0002, 32'h1111_0001, 32'h1010_0000};
      ar_q.push_back('{id: 4'd1, addr: 32'h1C00_0040, len: 8'd3});
      done_q.push_back('{pulses: 3'b010, data: dline});
      ar_q.push_back('{id: 4'd0, addr: 32'h1C00_0000, len: 8'd3});
      done_q.push_back('{pulses: 3'b100, data: iline});
      icache_ren   = 1'b1;
      icache_raddr = 32'h1C00_0000;
      cpu_ren      = 4'hF;
      cpu_raddr    = 32'h1C00_0040;
      #1;
      checks++;
      if ({icache_rrdy, dev_rrdy} !== 2'b01) begin
         errors++;
         $display("FAIL conflict_rdy got icache=%b dev=%b required icache=0 dev=1", icache_rrdy, dev_rrdy);
      end
      tick();
      cpu_ren = 4'h0;
      serve_read(dline, 4, 2'b00);
      while (axi.arvalid !== 1'b1 && t < 20) begin tick(); t++; end
      icache_ren = 1'b0;
      serve_read(iline, 4, 2'b00);
   endtask

   task automatic test_writeback();
      logic [127:0] wd = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
      aw_q.push_back('{id: 4'd1, addr: 32'h1C00_0300, len: 8'd3});
      for (int i = 0; i < 4; i++) w_q.push_back('{data: wd[32*i +: 32], strb: 4'hF, last: (i == 3)});
      cpu_wen   = 4'hF;
      cpu_waddr = 32'h1C00_0300;
      cpu_wdata = wd;
      tick();
      cpu_wen = 4'h0;
      checks++;
      if (dev_wrdy !== 1'b0) begin
         errors++;
         $display("FAIL wrdy_after_accept got %b required 0", dev_wrdy);
      end
      serve_write(1);
   endtask

   task automatic test_uncached_wr_rd();
      int t = 0;
      aw_q.push_back('{id: 4'd1, addr: 32'hBFAF_8000, len: 8'd0});
      w_q.push_back('{data: 32'h1234_5678, strb: 4'b0011, last: 1'b1});
      ar_q.push_back('{id: 4'd1, addr: 32'hBFAF_8000, len: 8'd0});
      done_q.push_back('{pulses: 3'b001, data: {96'b0, 32'hCAFE_F00D}});
      uncache_wen   = 4'b0011;
      uncache_waddr = 32'hBFAF_8000;
      uncache_wdata = 32'h1234_5678;
      tick();
      uncache_wen   = 4'b0000;
      uncache_ren   = 1'b1;
      uncache_raddr = 32'hBFAF_8000;
      serve_write(-1);
      while (axi.arvalid !== 1'b1 && t < 20) begin tick(); t++; end
      uncache_ren = 1'b0;
      serve_read({96'b0, 32'hCAFE_F00D}, 1, 2'b10);
   endtask

   task automatic test_reset_mid_burst();
      addr_exp_t ea;
      logic [2:0] seen = 3'b000;
      int t = 0;
      ar_q.push_back('{id: 4'd1, addr: 32'h1C00_0200, len: 8'd3});
      cpu_ren   = 4'hF;
      cpu_raddr = 32'h1C00_0200;
      tick();
      cpu_ren = 4'h0;
      while (axi.arvalid !== 1'b1 && t < 20) begin tick(); t++; end
      ea = ar_q.pop_front();
      checks++;
      if (axi.araddr !== ea.addr) begin
         errors++;
         $display("FAIL abort_araddr got %h required %h", axi.araddr, ea.addr);
      end
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         axi.rvalid = 1'b1;
         axi.rdata  = 32'h5500_0000 + 32'(i);
         tick();
      end
      axi.rvalid = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if ({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
           icache_rvalid, dev_rvalid, uncache_rvalid} !== 8'b0) begin
         errors++;
         $display("FAIL mid_reset_valids got %b required 00000000", {axi.arvalid, axi.rready,
                  axi.awvalid, axi.wvalid, axi.bready, icache_rvalid, dev_rvalid, uncache_rvalid});
      end
      checks++;
      if ({dev_rrdy, dev_wrdy, icache_rrdy, dev_rdata} !== {3'b111, 128'b0}) begin
         errors++;
         $display("FAIL mid_reset_idle got rrdy=%b wrdy=%b irdy=%b data=%h required 1 1 1 0",
                  dev_rrdy, dev_wrdy, icache_rrdy, dev_rdata);
      end
      tick();
      tick();
      rst = 1'b1;
      repeat (6) begin
         tick();
         seen = seen | {icache_rvalid, dev_rvalid, uncache_rvalid};
      end
      checks++;
      if (seen !== 3'b000) begin
         errors++;
         $display("FAIL post_reset_pulse got %b required 000", seen);
      end
      run_fill(32'h1C00_0404, {32'h7777_0003, 32'h6666_0002, 32'h5555_0001, 32'h4444_0000});
   endtask

   initial begin
      axi.arready = 1'b0;
      axi.rid     = 4'd0;
      axi.rdata   = '0;
      axi.rresp   = 2'b00;
      axi.rlast   = 1'b0;
      axi.rvalid  = 1'b0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bid     = 4'd1;
      axi.bresp   = 2'b00;
      axi.bvalid  = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      test_reset();
      tick();
      rst = 1'b1;
      tick();
      test_dcache_fill();
      tick();
      test_conflict();
      tick();
      test_writeback();
      tick();
      test_uncached_wr_rd();
      tick();
      test_reset_mid_burst();
      checks++;
      if (ar_q.size() + aw_q.size() + w_q.size() + done_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations got %0d required 0",
                  ar_q.size() + aw_q.size() + w_q.size() + done_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
